// File: rtl/a2d_scan_seq_if.sv
// Conversion handshake between the scan sequencer (master) and the A2D front end (slave).
interface a2d_scan_seq_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/a2d_scan_seq.sv
// Periodic A2D channel scanner: walks the latched channel mask and stores each result in an 8-entry table.
// Define A2D_AVG_EN to store a running average (3*old + new)/4 instead of the raw result.
module a2d_scan_seq #(
  parameter int PERIOD  = 50000,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [7:0]     chnl_mask,
  a2d_scan_seq_if.master a2d,
  input  logic [2:0]     rd_sel,
  output logic [11:0]    rd_res,
  output logic           busy,
  output logic           scan_done,
  output logic           overrun,
  output logic           tmo_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, SEEK, START, CONV, STORE, DONE} state_t;

  state_t        state, state_d;
  logic [15:0]   per_cnt;
  logic          tick;
  logic [7:0]    mask_q;
  logic [2:0]    idx;
  logic [2:0]    chnnl_q;
  logic [TW-1:0] tmo_cnt;
  logic          scan_start, idx_step, do_store, tmo_hit;
  logic [11:0]   res_tbl [8];
  logic [11:0]   store_val;

  assign tick      = en && (per_cnt == 16'(PERIOD - 1));
  assign busy      = (state != IDLE);
  assign scan_done = (state == DONE);
  assign a2d.strt_cnv = (state == START);
  assign a2d.chnnl    = chnnl_q;
  assign rd_res    = res_tbl[rd_sel];

  // A timed-out channel leaves the sequencer exactly as a stored one would, minus the write.
  always_comb begin
    state_d    = state;
    scan_start = 1'b0;
    idx_step   = 1'b0;
    do_store   = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (tick && chnl_mask != 8'h00) begin
          state_d    = SEEK;
          scan_start = 1'b1;
        end
      end
      SEEK: begin
        if (!en)                 state_d = IDLE;
        else if (mask_q[idx])    state_d = START;
        else if (idx == 3'd7)    state_d = DONE;
        else                     idx_step = 1'b1;
      end
      START: state_d = CONV;
      CONV: begin
        if (a2d.cnv_cmplt) begin
          state_d = STORE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          if (!en)               state_d = IDLE;
          else if (idx == 3'd7)  state_d = DONE;
          else begin
            state_d  = SEEK;
            idx_step = 1'b1;
          end
        end
      end
      STORE: begin
        do_store = 1'b1;
        if (!en)                 state_d = IDLE;
        else if (idx == 3'd7)    state_d = DONE;
        else begin
          state_d  = SEEK;
          idx_step = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      per_cnt <= '0;
      mask_q  <= '0;
      idx     <= '0;
      chnnl_q <= '0;
      tmo_cnt <= '0;
      overrun <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      state <= state_d;
      if (!en || tick) per_cnt <= '0;
      else             per_cnt <= per_cnt + 16'd1;
      if (scan_start) begin
        mask_q <= chnl_mask;
        idx    <= '0;
      end else if (idx_step) begin
        idx <= idx + 3'd1;
      end
      if (state == SEEK && state_d == START) chnnl_q <= idx;
      if (state == START)     tmo_cnt <= '0;
      else if (state == CONV) tmo_cnt <= tmo_cnt + TW'(1);
      if (tick && busy) overrun <= 1'b1;
      if (tmo_hit)      tmo_err <= 1'b1;
    end
  end

`ifdef A2D_AVG_EN
  // First sample per channel seeds the average so it does not ramp up from zero.
  logic [7:0]  valid;
  logic [13:0] avg_sum;

  assign avg_sum   = 14'd3 * {2'b00, res_tbl[idx]} + {2'b00, a2d.res};
  assign store_val = valid[idx] ? avg_sum[13:2] : a2d.res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           valid <= '0;
    else if (do_store) valid[idx] <= 1'b1;
  end
`else
  assign store_val = a2d.res;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) res_tbl[i] <= '0;
    end else if (do_store) begin
      res_tbl[idx] <= store_val;
    end
  end

endmodule

// File: tb/tb_a2d_scan_seq.sv
// Self-checking bench for a2d_scan_seq: randomized A2D responder plus a scoreboard of expected table contents.
module tb_a2d_scan_seq;

  localparam int PERIOD  = 50;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  chnl_mask;
  logic [2:0]  rd_sel;
  logic [11:0] rd_res;
  logic        busy, scan_done, overrun, tmo_err;

  a2d_scan_seq_if a2d ();

  a2d_scan_seq #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .chnl_mask (chnl_mask),
    .a2d       (a2d),
    .rd_sel    (rd_sel),
    .rd_res    (rd_res),
    .busy      (busy),
    .scan_done (scan_done),
    .overrun   (overrun),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          hang     = 1'b0;
  int          lat_min  = 1;
  int          lat_max  = 6;
  int          strt_cnt = 0;
  int          done_cnt = 0;
  bit          busy_seen = 1'b0;
  int          ch_q[$];
  int          cyc_q[$];
  logic [11:0] exp_table [8];
  bit   [7:0]  exp_valid;

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) exp_table[i] = '0;
    exp_valid = '0;
  endfunction

  function automatic void model_store(int ch, logic [11:0] v);
`ifdef A2D_AVG_EN
    if (exp_valid[ch]) exp_table[ch] = 12'((3 * int'(exp_table[ch]) + int'(v)) / 4);
    else               exp_table[ch] = v;
    exp_valid[ch] = 1'b1;
`else
    exp_table[ch] = v;
`endif
  endfunction

  // A2D front end: drops cnv_cmplt on a request, returns a random result after a random latency.
  initial begin
    int          pend_cnt;
    bit          pend;
    int          cur_ch;
    logic [11:0] v;
    pend = 1'b0;
    pend_cnt = 0;
    cur_ch = 0;
    a2d.cnv_cmplt = 1'b1;
    a2d.res = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        a2d.cnv_cmplt = 1'b1;
      end else begin
        if (scan_done) done_cnt++;
        if (busy) busy_seen = 1'b1;
        if (a2d.strt_cnv) begin
          strt_cnt++;
          ch_q.push_back(int'(a2d.chnnl));
          cyc_q.push_back(cyc);
          cur_ch = int'(a2d.chnnl);
          a2d.cnv_cmplt = 1'b0;
          pend = !hang;
          pend_cnt = int'($urandom_range(lat_max, lat_min));
        end else if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            v = 12'($urandom_range(4095, 0));
            a2d.res = v;
            a2d.cnv_cmplt = 1'b1;
            pend = 1'b0;
            model_store(cur_ch, v);
          end
        end
      end
    end
  end

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_table(string tag);
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      check_output($sformatf("%s tbl[%0d]", tag, i), rd_res, exp_table[i]);
    end
  endtask

  task automatic check_order(string tag, logic [7:0] m);
    int exp_q[$];
    for (int i = 0; i < 8; i++) if (m[i]) exp_q.push_back(i);
    check_output({tag, " conv count"}, ch_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ch_q.size(); i++)
      check_output($sformatf("%s conv %0d chnnl", tag, i), ch_q[i], exp_q[i]);
  endtask

  task automatic wait_done(string tag, int budget);
    int k = 0;
    while (!scan_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_output({tag, " scan_done seen"}, scan_done, 1);
  endtask

  task automatic wait_strt(string tag, int budget);
    int k = 0;
    while (!a2d.strt_cnv && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_output({tag, " strt_cnv seen"}, a2d.strt_cnv, 1);
  endtask

  task automatic apply_stimulus(string tag, logic [7:0] m);
    int d0;
    ch_q.delete();
    cyc_q.delete();
    d0 = done_cnt;
    chnl_mask = m;
    en = 1'b1;
    wait_done(tag, 600);
    en = 1'b0;
    @(negedge clk);
    check_order(tag, m);
    check_output({tag, " scan_done pulses"}, done_cnt - d0, 1);
    check_table(tag);
  endtask

  initial begin
    int          d0, s, k, r;
    logic [7:0]  m;
    rst = 1'b1;
    en = 1'b0;
    chnl_mask = '0;
    rd_sel = '0;
    model_clear();
    repeat (3) @(negedge clk);

    check_output("reset busy", busy, 0);
    check_output("reset scan_done", scan_done, 0);
    check_output("reset overrun", overrun, 0);
    check_output("reset tmo_err", tmo_err, 0);
    check_output("reset strt_cnv", a2d.strt_cnv, 0);
    check_output("reset chnnl", a2d.chnnl, 0);
    check_table("reset");
    rst = 1'b0;
    @(negedge clk);

    // Empty mask: ticks arrive but nothing may happen.
    chnl_mask = 8'h00;
    en = 1'b1;
    busy_seen = 1'b0;
    repeat (120) @(negedge clk);
    check_output("mask0 strt count", strt_cnt, 0);
    check_output("mask0 done count", done_cnt, 0);
    check_output("mask0 busy seen", busy_seen, 0);
    en = 1'b0;
    @(negedge clk);

    apply_stimulus("m05", 8'h05);
    check_output("m05 overrun", overrun, 0);

    lat_min = 1;
    lat_max = 3;
    for (int it = 0; it < 4; it++) begin
      m = 8'($urandom_range(255, 1));
      apply_stimulus($sformatf("rnd%0d", it), m);
    end

    // en withdrawn right after the first request: that result lands, then the scan stops quietly.
    lat_min = 4;
    lat_max = 6;
    ch_q.delete();
    d0 = done_cnt;
    chnl_mask = 8'hFF;
    en = 1'b1;
    wait_strt("endrop", 200);
    en = 1'b0;
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    check_output("endrop busy", busy, 0);
    check_output("endrop conv count", ch_q.size(), 1);
    check_output("endrop done pulses", done_cnt - d0, 0);
    check_table("endrop");

    // Converter never answers.
    check_output("pre tmo_err", tmo_err, 0);
    hang = 1'b1;
    ch_q.delete();
    d0 = done_cnt;
    chnl_mask = 8'h01;
    en = 1'b1;
    wait_strt("tmo", 200);
    s = cyc;
    k = 0;
    while (!tmo_err && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_output("tmo latency", cyc - s, 16);
    wait_done("tmo", 100);
    en = 1'b0;
    @(negedge clk);
    check_output("tmo done pulses", done_cnt - d0, 1);
    check_output("tmo sticky", tmo_err, 1);
    check_table("tmo");
    hang = 1'b0;

    // Long conversions over all channels outlast the tick period.
    lat_min = 10;
    lat_max = 12;
    apply_stimulus("ovr", 8'hFF);
    check_output("ovr overrun", overrun, 1);
    check_output("ovr tmo_err still set", tmo_err, 1);

    // Reset in the middle of a conversion.
    ch_q.delete();
    chnl_mask = 8'h81;
    en = 1'b1;
    wait_strt("rstmid", 200);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rstmid busy", busy, 0);
    check_output("rstmid strt_cnv", a2d.strt_cnv, 0);
    check_output("rstmid chnnl", a2d.chnnl, 0);
    check_output("rstmid overrun", overrun, 0);
    check_output("rstmid tmo_err", tmo_err, 0);
    model_clear();
    check_table("rstmid");
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
    ch_q.delete();
    cyc_q.delete();
    d0 = done_cnt;
    wait_done("rstpost", 300);
    en = 1'b0;
    @(negedge clk);
    check_order("rstpost", 8'h81);
    check_output("rstpost first strt delay", (cyc_q.size() > 0) ? cyc_q[0] - r : -1, PERIOD + 1);
    check_output("rstpost done pulses", done_cnt - d0, 1);
    check_table("rstpost");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/a2d_scan_seq.md
A2D_SCAN_SEQ -- requirements
Module: a2d_scan_seq

Interface
REQ-001 Parameter PERIOD, default 50000: scan-tick interval in clk cycles; legal range 2..65535.
REQ-002 Parameter TIMEOUT, default 1023: maximum clk cycles to wait for cnv_cmplt per channel.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  scan enable.
REQ-006 Port chnl_mask  input  8  bit i=1 selects channel i for scanning.
REQ-007 Port strt_cnv  output  1  one-cycle conversion request to the A2D interface.
REQ-008 Port chnnl  output  3  channel number for the conversion in progress.
REQ-009 Port cnv_cmplt  input  1  level from the A2D interface; cleared by it on strt_cnv, set on completion.
REQ-010 Port res  input  12  conversion result; valid while cnv_cmplt=1.
REQ-011 Port rd_sel  input  3  result-table read index.
REQ-012 Port rd_res  output  12  stored result for channel rd_sel, combinational read.
REQ-013 Port busy  output  1  high whenever state is not IDLE.
REQ-014 Port scan_done  output  1  one-cycle pulse at the end of a complete scan.
REQ-015 Port overrun  output  1  sticky: a tick arrived while busy.
REQ-016 Port tmo_err  output  1  sticky: a conversion exceeded TIMEOUT.

Function
REQ-017 Period counter: cleared while en=0; otherwise counts 0..PERIOD-1 and wraps; tick is asserted in the cycle the count equals PERIOD-1.
REQ-018 States: IDLE, SEEK, START, CONV, STORE, DONE.
REQ-019 IDLE->SEEK on tick with en=1 and chnl_mask!=0; chnl_mask is latched and the channel index is cleared to 0 on this transition.
REQ-020 A tick with chnl_mask=0 is ignored: no scan, no scan_done.
REQ-021 SEEK examines one index per cycle: latched bit set -> START; bit clear and index<7 -> index+1; bit clear and index=7 -> DONE.
REQ-022 START asserts strt_cnv for exactly one cycle with chnnl=index, then goes to CONV; the timeout counter is cleared.
REQ-023 chnnl is registered and holds its value from START until the channel's STORE completes or times out.
REQ-024 CONV waits for cnv_cmplt=1, then goes to STORE; cnv_cmplt is not sampled in the START cycle.
REQ-025 CONV timeout: on the TIMEOUT-th cycle without cnv_cmplt, set tmo_err, skip the store, and continue as from STORE.
REQ-026 STORE writes res to table[index]; if index=7 go to DONE, else increment index and go to SEEK.
REQ-027 DONE pulses scan_done for one cycle, then goes to IDLE.
REQ-028 A tick while busy sets overrun and is otherwise dropped.
REQ-029 en falling mid-scan: the current conversion completes, its result is stored, then the block returns to IDLE without scan_done.
REQ-030 overrun and tmo_err clear only on rst.

Reset
REQ-031 While rst=1: state=IDLE, index=0, chnnl=0, strt_cnv=0, busy=0, scan_done=0, overrun=0, tmo_err=0, period counter=0, all eight table entries=0.
REQ-032 rst asserted mid-conversion aborts immediately; the first scan after release starts on a fresh tick.

Configuration
REQ-033 Macro A2D_AVG_EN defined: STORE writes (3*old + res)>>2 using a 14-bit intermediate; the first store to each channel after reset writes res directly, tracked by a per-channel valid bit.
REQ-034 Macro A2D_AVG_EN undefined: STORE writes res directly, and no per-channel valid bits exist.

Verification
REQ-035 PERIOD=20, chnl_mask=8'h05, model returns 12'hABC after 40 cycles -> strt_cnv with chnnl=0 then chnnl=2, table[0]=table[2]=12'hABC, one scan_done pulse.
REQ-036 chnl_mask=8'h00, en=1 for 100 cycles -> strt_cnv, busy and scan_done never assert.
REQ-037 Model never asserts cnv_cmplt, TIMEOUT=15, mask=8'h01 -> tmo_err=1 16 cycles after strt_cnv, table[0] unchanged, scan_done pulses.
REQ-038 PERIOD=4, 40-cycle conversions, mask=8'hFF -> overrun=1, all 8 channels stored in order 0..7.
REQ-039 A2D_AVG_EN defined, channel 1 fed 12'h400 then 12'h800 -> table[1]=12'h400, then 12'h500.
REQ-040 rst pulsed while in CONV -> all outputs and the table read 0 immediately; the next scan begins at chnnl=0.
